// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - FFT frame controller: input framing, credits, ping-pong reorder buffer sequencing
// Define FFT_CTRL_BITREV_EN to write bit-reversed addresses so frames are read out in natural order.
module fft_frame_ctrl #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         fft_start,
  input  logic         fft_done,
  output logic         wr_en,
  output logic         wr_bank,
  output logic [N-1:0] wr_addr,
  output logic         rd_en,
  output logic         rd_bank,
  output logic [N-1:0] rd_addr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         out_last,
  output logic         err_gap,
  output logic         err_overrun
);

  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] LAST      = {N{1'b1}};
  localparam logic [N-1:0] LOAD_LAST = {{(N-1){1'b1}}, 1'b0};

  typedef enum logic {S_IDLE, S_LOAD} in_state_t;

  in_state_t    r_in_state;
  logic [N-1:0] r_in_cnt;
  logic [1:0]   r_credit;
  logic         r_in_ready;
  logic         r_err_gap;

  logic         r_wr_busy;
  logic [N-1:0] r_wr_cnt;
  logic         r_wr_bank;
  logic [1:0]   r_full;
  logic         r_rd_bank;
  logic [N-1:0] r_rd_cnt;
  logic         r_out_valid;
  logic         r_out_last;
  logic         r_err_overrun;

  logic         w_accept;
  logic         w_load_end;
  logic         w_load_next;
  logic         w_wr_start;
  logic         w_wr_end;
  logic [N-1:0] w_wr_cnt;
  logic         w_rd_go;
  logic         w_rd_end;
  logic [1:0]   w_credit_next;
  logic [1:0]   w_full_next;

  // Sample 0 is taken in IDLE; LOAD covers samples 1..2^N-1.
  assign w_accept    = (r_in_state == S_IDLE) & r_in_ready & in_valid;
  assign w_load_end  = (r_in_state == S_LOAD) & (r_in_cnt == LOAD_LAST);
  assign w_load_next = w_accept | ((r_in_state == S_LOAD) & ~w_load_end);

  assign w_wr_start  = fft_done & ~r_wr_busy & ~rst;
  assign w_wr_end    = r_wr_busy & (r_wr_cnt == LAST);
  assign w_wr_cnt    = r_wr_busy ? r_wr_cnt : '0;

  assign w_rd_go     = r_full[r_rd_bank] & out_ready & ~rst;
  assign w_rd_end    = w_rd_go & (r_rd_cnt == LAST);

  always_comb begin
    w_credit_next = r_credit;
    if (w_rd_end && !w_accept) begin
      if (r_credit != 2'd2) w_credit_next = r_credit + 2'd1;
    end else if (w_accept && !w_rd_end) begin
      w_credit_next = r_credit - 2'd1;
    end
  end

  always_comb begin
    w_full_next = r_full;
    if (w_rd_end) w_full_next[r_rd_bank] = 1'b0;
    if (w_wr_end) w_full_next[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_state <= S_IDLE;
      r_in_cnt   <= '0;
      r_credit   <= 2'd2;
      r_in_ready <= 1'b0;
      r_err_gap  <= 1'b0;
    end else begin
      r_credit   <= w_credit_next;
      r_in_ready <= w_load_next | (w_credit_next != 2'd0);
      case (r_in_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_state <= S_LOAD;
            r_in_cnt   <= '0;
          end
        end
        S_LOAD: begin
          r_in_cnt <= r_in_cnt + ONE;
          if (!in_valid) r_err_gap <= 1'b1;
          if (w_load_end) r_in_state <= S_IDLE;
        end
        default: r_in_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_busy     <= 1'b0;
      r_wr_cnt      <= '0;
      r_wr_bank     <= 1'b0;
      r_full        <= 2'b00;
      r_rd_bank     <= 1'b0;
      r_rd_cnt      <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_wr_start) begin
        r_wr_busy <= 1'b1;
        r_wr_cnt  <= ONE;
      end else if (r_wr_busy) begin
        r_wr_cnt <= r_wr_cnt + ONE;
        if (fft_done) r_err_overrun <= 1'b1;
        if (w_wr_end) begin
          r_wr_busy <= 1'b0;
          r_wr_bank <= ~r_wr_bank;
        end
      end
      // Read data appears one cycle after the strobe, matching the RAM latency.
      r_out_valid <= w_rd_go;
      r_out_last  <= w_rd_end;
      if (w_rd_go) r_rd_cnt <= r_rd_cnt + ONE;
      if (w_rd_end) r_rd_bank <= ~r_rd_bank;
    end
  end

`ifdef FFT_CTRL_BITREV_EN
  always_comb begin
    for (int i = 0; i < N; i++) wr_addr[i] = w_wr_cnt[N-1-i];
  end
`else
  assign wr_addr = w_wr_cnt;
`endif

  assign in_ready    = r_in_ready;
  assign fft_start   = w_accept;
  assign wr_en       = w_wr_start | r_wr_busy;
  assign wr_bank     = r_wr_bank;
  assign rd_en       = w_rd_go;
  assign rd_bank     = r_rd_bank;
  assign rd_addr     = r_rd_cnt;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign err_gap     = r_err_gap;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - self-checking bench for fft_frame_ctrl with a behavioural frame/bank model
module tb_fft_frame_ctrl;

  localparam int N     = 3;
  localparam int FRAME = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         fft_done = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, fft_start, wr_en, wr_bank, rd_en, rd_bank;
  logic         out_valid, out_last, err_gap, err_overrun;
  logic [N-1:0] wr_addr, rd_addr;

  fft_frame_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fft_start(fft_start), .fft_done(fft_done),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .err_gap(err_gap), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: frames in flight as plain counters, completed banks as a FIFO of bank numbers.
  bit m_fresh, m_load, m_wr_active, m_wr_bank, m_rd_bank, m_ov, m_ol, m_gap, m_over;
  int m_in_cnt, m_credit, m_wr_idx, m_rd_idx;
  int m_fill_q[$];
  int done_q[$];
  bit auto_done = 1'b0;
  int done_lat  = 20;

  int c0 = 0;
  bit log_start[128], log_ready[128], log_wr_en[128], log_wr_bank[128];
  bit log_rd_en[128], log_rd_bank[128], log_ov[128], log_ol[128], log_gap[128], log_over[128];
  int log_wr_addr[128], log_rd_addr[128];
  int lit_wr[8];

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endfunction

  function automatic int addr_map(int idx);
`ifdef FFT_CTRL_BITREV_EN
    int r = 0;
    for (int b = 0; b < N; b++) if ((idx & (1 << b)) != 0) r = r | (1 << (N - 1 - b));
    return r;
`else
    return idx;
`endif
  endfunction

  function automatic void model_reset();
    m_fresh = 1; m_load = 0; m_in_cnt = 0; m_credit = 2;
    m_wr_active = 0; m_wr_idx = 0; m_wr_bank = 0;
    m_rd_bank = 0; m_rd_idx = 0; m_ov = 0; m_ol = 0; m_gap = 0; m_over = 0;
    m_fill_q.delete();
    done_q.delete();
  endfunction

  always @(negedge clk) begin
    bit e_ready, e_start, e_wr_en, e_rd_en, drained;
    int e_wr_addr, rel;
    if (rst) begin
      chk("reset_outputs", int'({in_ready, fft_start, wr_en, wr_bank, wr_addr, rd_en, rd_bank,
                                 rd_addr, out_valid, out_last, err_gap, err_overrun}), 0);
      model_reset();
    end else begin
      e_ready   = !m_fresh && (m_load || m_credit > 0);
      e_start   = !m_load && e_ready && (in_valid == 1'b1);
      e_wr_en   = m_wr_active || (fft_done == 1'b1);
      e_wr_addr = addr_map(m_wr_active ? m_wr_idx : 0);
      e_rd_en   = (m_fill_q.size() > 0) && (out_ready == 1'b1);

      chk("in_ready", int'(in_ready), int'(e_ready));
      chk("fft_start", int'(fft_start), int'(e_start));
      chk("wr_en", int'(wr_en), int'(e_wr_en));
      chk("wr_bank", int'(wr_bank), int'(m_wr_bank));
      if (e_wr_en) chk("wr_addr", int'(wr_addr), e_wr_addr);
      chk("rd_en", int'(rd_en), int'(e_rd_en));
      chk("rd_bank", int'(rd_bank), int'(m_rd_bank));
      if (e_rd_en) chk("rd_addr", int'(rd_addr), m_rd_idx);
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_last", int'(out_last), int'(m_ol));
      chk("err_gap", int'(err_gap), int'(m_gap));
      chk("err_overrun", int'(err_overrun), int'(m_over));

      rel = cyc - c0;
      if (rel >= 0 && rel < 128) begin
        log_start[rel] = fft_start;  log_ready[rel] = in_ready;
        log_wr_en[rel] = wr_en;      log_wr_bank[rel] = wr_bank; log_wr_addr[rel] = int'(wr_addr);
        log_rd_en[rel] = rd_en;      log_rd_bank[rel] = rd_bank; log_rd_addr[rel] = int'(rd_addr);
        log_ov[rel] = out_valid;     log_ol[rel] = out_last;
        log_gap[rel] = err_gap;      log_over[rel] = err_overrun;
      end

      drained = 0;
      m_ov = e_rd_en;
      m_ol = e_rd_en && (m_rd_idx == FRAME - 1);
      if (e_rd_en) begin
        m_rd_idx++;
        if (m_rd_idx == FRAME) begin
          void'(m_fill_q.pop_front());
          m_rd_bank = !m_rd_bank;
          m_rd_idx  = 0;
          drained   = 1;
        end
      end
      if (m_wr_active) begin
        if (fft_done == 1'b1) m_over = 1;
        m_wr_idx++;
        if (m_wr_idx == FRAME) begin
          m_fill_q.push_back(int'(m_wr_bank));
          m_wr_bank   = !m_wr_bank;
          m_wr_active = 0;
        end
      end else if (fft_done == 1'b1) begin
        m_wr_active = 1;
        m_wr_idx    = 1;
      end
      if (e_start) begin
        m_load = 1;
        m_in_cnt = 1;
        if (auto_done) done_q.push_back(cyc + done_lat);
      end else if (m_load) begin
        if (in_valid == 1'b0) m_gap = 1;
        if (m_in_cnt == FRAME - 1) m_load = 0;
        m_in_cnt++;
      end
      m_credit = m_credit - (e_start ? 1 : 0) + (drained ? 1 : 0);
      if (m_credit > 2) m_credit = 2;
      m_fresh = 0;
    end
  end

  task automatic step(input bit iv, input bit ordy, input bit fd);
    bit due;
    @(posedge clk);
    #1;
    due = (done_q.size() > 0) && (done_q[0] == cyc);
    if (due) void'(done_q.pop_front());
    in_valid  = iv;
    out_ready = ordy;
    fft_done  = fd | due;
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fft_done = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = cyc + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc;
`ifdef FFT_CTRL_BITREV_EN
    lit_wr = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    lit_wr = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    model_reset();

    // Streaming input, fft_done 20 cycles after each start, reader always ready.
    do_reset(3);
    auto_done = 1; done_lat = 20;
    for (int i = 0; i < 64; i++) step(1, 1, 0);
    acc = 0;
    for (int i = 0; i < 16; i++) acc += int'(log_start[i]);
    chk("p1_start_count", acc, 2);
    chk("p1_start_c0", int'(log_start[0]), 1);
    chk("p1_start_c8", int'(log_start[8]), 1);
    acc = 0;
    for (int i = 0; i < 16; i++) acc += int'(log_ready[i]);
    chk("p1_accepted", acc, 16);
    chk("p1_no_credit_c16", int'(log_ready[16]), 0);
    chk("p1_wr_idle_c19", int'(log_wr_en[19]), 0);
    for (int i = 0; i < 8; i++) begin
      chk("p1_wr_en", int'(log_wr_en[20+i]), 1);
      chk("p1_wr_addr", log_wr_addr[20+i], lit_wr[i]);
      chk("p1_wr_bank", int'(log_wr_bank[20+i]), 0);
      chk("p1_rd_en", int'(log_rd_en[28+i]), 1);
      chk("p1_rd_addr", log_rd_addr[28+i], i);
      chk("p1_out_valid", int'(log_ov[29+i]), 1);
      chk("p1_out_last", int'(log_ol[29+i]), (i == 7) ? 1 : 0);
    end
    chk("p1_rd_idle_c27", int'(log_rd_en[27]), 0);
    chk("p1_ov_idle_c28", int'(log_ov[28]), 0);
    chk("p1_wr_bank1_c28", int'(log_wr_bank[28]), 1);
    chk("p1_rd_bank0_c28", int'(log_rd_bank[28]), 0);

    // Downstream stalled: two frames fill both banks, the third waits for a drain.
    do_reset(2);
    for (int i = 0; i < 60; i++) step(1, 0, 0);
    for (int i = 60; i < 80; i++) step(1, 1, 0);
    chk("p2_ready_c15", int'(log_ready[15]), 1);
    chk("p2_ready_c16", int'(log_ready[16]), 0);
    chk("p2_ready_c50", int'(log_ready[50]), 0);
    chk("p2_rd_c60", int'(log_rd_en[60]), 1);
    chk("p2_ready_c67", int'(log_ready[67]), 0);
    chk("p2_ready_c68", int'(log_ready[68]), 1);
    chk("p2_start_c68", int'(log_start[68]), 1);

    // Input gap at sample 3, then a second fft_done 4 cycles into a write.
    do_reset(2);
    auto_done = 0;
    for (int i = 0; i < 40; i++) step(i != 3, 1, (i == 20) || (i == 24));
    chk("p3_gap_c3", int'(log_gap[3]), 0);
    chk("p3_gap_c4", int'(log_gap[4]), 1);
    chk("p3_ready_c7", int'(log_ready[7]), 1);
    chk("p3_start_c8", int'(log_start[8]), 1);
    chk("p3_over_c24", int'(log_over[24]), 0);
    chk("p3_over_c25", int'(log_over[25]), 1);
    chk("p3_wr_c27", int'(log_wr_en[27]), 1);
    chk("p3_wr_c28", int'(log_wr_en[28]), 0);

    // Reset in the middle of LOAD abandons the frame.
    do_reset(2);
    auto_done = 1; done_lat = 20;
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    do_reset(2);
    auto_done = 0;
    for (int i = 0; i < 40; i++) step(0, 1, 0);
    for (int i = 40; i < 60; i++) step(1, 0, 0);
    acc = 0;
    for (int i = 0; i < 40; i++) acc += int'(log_ov[i]);
    chk("p4_no_out_valid", acc, 0);
    chk("p4_ready_c0", int'(log_ready[0]), 1);
    chk("p4_start_c40", int'(log_start[40]), 1);
    chk("p4_start_c48", int'(log_start[48]), 1);
    chk("p4_ready_c56", int'(log_ready[56]), 0);

    // Randomized traffic with occasional overruns and resets.
    do_reset(2);
    auto_done = 1; done_lat = 12;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(699, 0) == 0) begin
        do_reset(int'($urandom_range(3, 1)));
        done_lat = int'($urandom_range(24, 9));
      end
      step($urandom_range(7, 0) != 0, $urandom_range(3, 0) != 0,
           m_wr_active && ($urandom_range(49, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, meaning log2 of the frame length (2^N points), range 2..10.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, upstream sample present this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit, controller accepts a sample this cycle.
REQ-006 SHALL have port fft_start, output, 1 bit, one-cycle pulse to the butterfly pipeline start input, coincident with sample 0 of a frame.
REQ-007 SHALL have port fft_done, input, 1 bit, pipeline output-start pulse, coincident with output sample 0 of a frame.
REQ-008 SHALL have ports wr_en (1 bit), wr_bank (1 bit) and wr_addr (N bits), all outputs, the reorder-buffer write strobe, bank and address.
REQ-009 SHALL have ports rd_en (1 bit), rd_bank (1 bit) and rd_addr (N bits), all outputs, the reorder-buffer read strobe, bank and address.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accepts output.
REQ-011 SHALL have ports out_valid and out_last, outputs, 1 bit each: read data valid, and last sample of the frame.
REQ-012 SHALL have ports err_gap and err_overrun, outputs, 1 bit each, sticky error flags.

Function
REQ-013 SHALL run an input FSM with states IDLE and LOAD, and hold a credit counter (0..2) for the two ping-pong banks.
REQ-014 SHALL drive in_ready=1 in IDLE when credit>0, and SHALL drive in_ready=1 throughout LOAD.
REQ-015 SHALL, in IDLE with in_valid&in_ready, pulse fft_start, decrement credit, clear the input count and enter LOAD.
REQ-016 SHALL increment the input count every LOAD cycle whether or not in_valid is high, and return to IDLE after sample 2^N-1.
REQ-017 SHALL set err_gap if in_valid=0 in any LOAD cycle, and SHALL let the frame complete anyway.
REQ-018 SHALL, on fft_done while the writer is idle, assert wr_en for 2^N consecutive cycles starting that cycle, with wr_bank held at the current write bank.
REQ-019 SHALL, at the end of those 2^N write cycles, mark the write bank full and toggle the write bank.
REQ-020 SHALL, on fft_done while the writer is busy, ignore the pulse and set err_overrun.
REQ-021 SHALL start the reader when the read bank is full; each cycle with out_ready=1 it SHALL assert rd_en with rd_addr=0..2^N-1 in sequence, and stall with rd_en=0 when out_ready=0.
REQ-022 SHALL assert out_valid exactly one cycle after each rd_en, to match the 1-cycle RAM read latency, and assert out_last with the out_valid of address 2^N-1.
REQ-023 SHALL, after reading address 2^N-1, mark the read bank empty, toggle the read bank and increment credit.
REQ-024 SHALL apply the credit increment and decrement together when both fall in the same cycle (net 0), and SHALL never let credit exceed 2.
REQ-025 SHALL allow the reader to start on one bank in the same cycle as the writer finishes the other.

Reset
REQ-026 SHALL, on rst, put both FSMs in IDLE, set credit=2, both banks empty, write and read bank=0, counters=0.
REQ-027 SHALL drive all outputs 0 during and after reset, including err flags; in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-028 SHALL, on rst mid-frame, abandon in-flight frames; no output is produced for them.

Configuration
REQ-029 SHALL, with macro FFT_CTRL_BITREV_EN defined, drive wr_addr as the bit-reverse of the write count, so the output is in natural order.
REQ-030 SHALL, with FFT_CTRL_BITREV_EN undefined, drive wr_addr as the plain write count, so the output keeps pipeline order; all other behaviour is unchanged.

Verification (N=3)
REQ-031 SHALL check: reset, then in_valid held high -> fft_start pulses at cycles 0 and 8, and 8 accepted samples per frame.
REQ-032 SHALL check: fft_done at cycle 20 with FFT_CTRL_BITREV_EN -> wr_en cycles 20..27 with wr_addr 0,4,2,6,1,5,3,7 on bank 0; without the macro, 0..7.
REQ-033 SHALL check: bank full with out_ready=1 -> rd_addr 0..7, out_valid one cycle later, out_last on the 8th.
REQ-034 SHALL check: out_ready=0 forever with three frames offered -> in_ready=0 after 2 frames, and it returns one cycle after the first bank is drained.
REQ-035 SHALL check: in_valid dropped at LOAD sample 3 -> err_gap=1 and the frame still ends after 8 cycles; fft_done 4 cycles into a write -> err_overrun=1.
REQ-036 SHALL check: rst asserted mid-LOAD -> in_ready=0, credit 2 and no out_valid afterwards.
